// File: rtl/btn_conditioner.sv
// N-channel push-button front end: 2-FF synchroniser, stable-count debouncer,
// registered press/release pulses and hold-to-repeat step strobes, all on sys_clk.

module btn_channel #(
    parameter int DEB_CYCLES = 2_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 10_000_000,
    parameter bit REP_ON     = 1'b1
) (
    input  logic sys_clk,
    input  logic Reset,
    input  logic pb,
    output logic dpb,
    output logic press,
    output logic rel,
    output logic rpt,
    output logic step
);
    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

    logic          ff1, ff2;
    logic          deb;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_last;
    state_t        state;

    // deb is the internal debounced level; dpb and the pulses are registered
    // from it one edge later so press/release line up with the dpb edge.
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            ff1     <= 1'b0;
            ff2     <= 1'b0;
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            ff1 <= pb;
            ff2 <= ff1;
            if (ff2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= ff2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign rep_last = (state == FIRST) ? DLY_LAST : PER_LAST;

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            rep_cnt <= '0;
            dpb     <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
            rpt     <= 1'b0;
            step    <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            rpt   <= 1'b0;
            step  <= 1'b0;
            case (state)
                IDLE: begin
                    rep_cnt <= '0;
                    if (deb) begin
                        state <= FIRST;
                        dpb   <= 1'b1;
                        press <= 1'b1;
                        step  <= 1'b1;
                    end
                end
                FIRST, REPEAT: begin
                    // A falling edge takes precedence over a repeat due this cycle.
                    if (!deb) begin
                        state   <= IDLE;
                        dpb     <= 1'b0;
                        rel     <= 1'b1;
                        rep_cnt <= '0;
                    end else if (!REP_ON) begin
                        rep_cnt <= '0;
                    end else if (rep_cnt == rep_last) begin
                        state   <= REPEAT;
                        rpt     <= 1'b1;
                        step    <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dpb     <= 1'b0;
                    rep_cnt <= '0;
                end
            endcase
        end
    end
endmodule

module btn_conditioner #(
    parameter int             N          = 5,
    parameter int             DEB_CYCLES = 2_000_000,
    parameter int             REP_DELAY  = 50_000_000,
    parameter int             REP_PERIOD = 10_000_000,
    parameter logic [N-1:0]   REP_EN     = 5'b01111
) (
    input  logic         sys_clk,
    input  logic         Reset,
    input  logic [N-1:0] pb,
    output logic [N-1:0] dpb,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,      // release pulse; "release" is a reserved word
    output logic [N-1:0] rpt,
    output logic [N-1:0] step
);
    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .REP_ON     (REP_EN[i])
        ) u_ch (
            .sys_clk (sys_clk),
            .Reset   (Reset),
            .pb      (pb[i]),
            .dpb     (dpb[i]),
            .press   (press[i]),
            .rel     (rel[i]),
            .rpt     (rpt[i]),
            .step    (step[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected per-edge outputs are queued when
// a pb plan is applied and popped against the DUT one edge at a time.

module tb_btn_conditioner;
    localparam int N  = 5;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int NONE = 1000;

    typedef struct packed {
        logic [N-1:0] dpb;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
        logic [N-1:0] step;
    } obs_t;

    logic         sys_clk = 1'b0;
    logic         Reset   = 1'b1;
    logic [N-1:0] pb      = '0;
    logic [N-1:0] dpb, press, rel, rpt, step;
    logic [N-1:0] ren     = 5'b01111;
    obs_t         obs;

    obs_t         exp_q[$];
    string        tag_q[$];
    logic [N-1:0] plan[$];
    int           pe[N];
    int           re[N];
    int           tests = 0;
    int           fails = 0;

    btn_conditioner #(
        .N(N), .DEB_CYCLES(DC), .REP_DELAY(RD), .REP_PERIOD(RP), .REP_EN(5'b01111)
    ) dut (
        .sys_clk (sys_clk),
        .Reset   (Reset),
        .pb      (pb),
        .dpb     (dpb),
        .press   (press),
        .rel     (rel),
        .rpt     (rpt),
        .step    (step)
    );

    always #5 sys_clk = ~sys_clk;
    assign obs = '{dpb: dpb, press: press, rel: rel, rpt: rpt, step: step};

    task automatic clear_marks();
        for (int c = 0; c < N; c++) begin
            pe[c] = NONE;
            re[c] = NONE;
        end
    endtask

    // Expected outputs at edge e given each channel's press edge and release edge.
    task automatic push_edge(string tag, int e);
        obs_t o;
        o = '0;
        for (int c = 0; c < N; c++) begin
            o.dpb[c]   = (e >= pe[c]) && (e < re[c]);
            o.press[c] = (e == pe[c]);
            o.rel[c]   = (e == re[c]);
            o.rpt[c]   = ren[c] && (e >= pe[c] + RD) && (e < re[c]) && ((e - pe[c] - RD) % RP == 0);
            o.step[c]  = o.press[c] | o.rpt[c];
        end
        exp_q.push_back(o);
        tag_q.push_back($sformatf("%s@e%0d", tag, e));
    endtask

    task automatic compare_now();
        obs_t  x;
        string t;
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === x) else begin
            fails++;
            $error("FAIL %s: observed dpb=%b press=%b rel=%b rpt=%b step=%b expected dpb=%b press=%b rel=%b rpt=%b step=%b",
                   t, obs.dpb, obs.press, obs.rel, obs.rpt, obs.step, x.dpb, x.press, x.rel, x.rpt, x.step);
        end
    endtask

    // Apply plan[e] so edge e samples it, then check outputs just after edge e.
    task automatic run(string tag, int n);
        for (int e = 0; e < n; e++) push_edge(tag, e);
        for (int e = 0; e < n; e++) begin
            if (e < plan.size()) pb = plan[e];
            @(posedge sys_clk);
            #1;
            compare_now();
        end
        plan.delete();
    endtask

    initial begin
        clear_marks();
        repeat (2) @(posedge sys_clk);
        #1;
        push_edge("reset_state", 0);
        compare_now();
        Reset = 1'b0;
        run("idle", 4);

        // T1: clean press on ch0, held 20 samples
        clear_marks();
        pe[0] = 6; re[0] = 26;
        for (int e = 0; e < 32; e++) plan.push_back((e < 20) ? 5'b00001 : 5'b00000);
        run("t1_ch0_hold", 32);

        // T2: 3-sample glitch on ch1 never debounces
        clear_marks();
        for (int e = 0; e < 15; e++) plan.push_back((e < 3) ? 5'b00010 : 5'b00000);
        run("t2_ch1_glitch", 15);

        // T3: long hold on ch2; repeat due at release edge is suppressed
        clear_marks();
        pe[2] = 6; re[2] = 46;
        for (int e = 0; e < 52; e++) plan.push_back((e < 40) ? 5'b00100 : 5'b00000);
        run("t3_ch2_repeat", 52);

        // T4: ch4 has repeat disabled
        clear_marks();
        pe[4] = 6; re[4] = 46;
        for (int e = 0; e < 52; e++) plan.push_back((e < 40) ? 5'b10000 : 5'b00000);
        run("t4_ch4_norep", 52);

        // T6: ch0 and ch3 rise together, ch3 drops for one sample
        clear_marks();
        pe[0] = 6; pe[3] = 8; re[0] = 36; re[3] = 36;
        for (int e = 0; e < 42; e++)
            plan.push_back((e == 1) ? 5'b00001 : (e < 30) ? 5'b01001 : 5'b00000);
        run("t6_bounce", 42);

        // T5: ch3 held, reset asserted mid-hold at edge 20
        clear_marks();
        pe[3] = 6;
        for (int e = 0; e < 20; e++) plan.push_back(5'b01000);
        run("t5_pre_reset", 20);
        Reset = 1'b1;
        #2;
        clear_marks();
        push_edge("t5_async_clear", 0);
        compare_now();
        @(posedge sys_clk);
        #1;
        push_edge("t5_in_reset", 0);
        compare_now();
        Reset = 1'b0;
        pe[3] = 6;
        run("t5_after_reset", 20);
        clear_marks();
        pe[3] = -14; re[3] = 6;
        for (int e = 0; e < 12; e++) plan.push_back(5'b00000);
        run("t5_release", 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
